// File: rtl/mdr_mem_interface_pkg.sv
// mdr_mem_interface_pkg: shared state encoding and default widths for the MDR/MAR memory sequencer
package mdr_mem_interface_pkg;
  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_RD   = 2'd1,
    MEM_WR   = 2'd2,
    MEM_FIN  = 2'd3
  } mem_state_t;
  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 32;
endpackage

// File: rtl/mdr_mem_interface_timer.sv
// mem_wait_timer: counts request cycles without ack; expired flags the last allowed wait cycle
module mem_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clock,
  input  logic clear,
  input  logic start,
  input  logic tick,
  output logic expired
);
  localparam int CW = TIMEOUT > 2 ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] cnt;
  always_ff @(posedge clock)
    if (!clear || start) cnt <= '0;
    else if (tick) cnt <= cnt + CW'(1);
  assign expired = cnt == CW'(TIMEOUT - 1);
endmodule

// File: rtl/mdr_mem_interface.sv
// mdr_mem_interface: MAR/MDR registers with a single-word req/ack memory read/write sequencer
module mdr_mem_interface
  import mdr_mem_interface_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [DATA_W-1:0] BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              rd_start,
  input  logic              wr_start,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mdr_q,
  output logic [ADDR_W-1:0] mar_q,
  output logic              busy,
  output logic              done,
  output logic              err
);
  mem_state_t state, state_d;
  logic err_d, expired, idle, in_req;
  assign idle   = state == MEM_IDLE;
  assign in_req = state == MEM_RD || state == MEM_WR;
  // Timer is held clear while idle so it starts at zero on every RD/WR entry
  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clock   (clock),
    .clear   (clear),
    .start   (idle),
    .tick    (in_req && !mem_ack),
    .expired (expired)
  );
  always_ff @(posedge clock)
    if (!clear) state <= MEM_IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    err_d   = 1'b0;
    if (idle) begin
      err_d   = rd_start && wr_start;
      state_d = err_d ? MEM_IDLE : rd_start ? MEM_RD : wr_start ? MEM_WR : MEM_IDLE;
    end else if (in_req) begin
      state_d = mem_ack ? MEM_FIN : expired ? MEM_IDLE : state;
      err_d   = !mem_ack && expired;
    end else begin
      state_d = MEM_IDLE;
    end
  end
  // Bus loads only in IDLE; a bus load into MDR beats nothing else since reads land later
  always_ff @(posedge clock)
    if (!clear) begin
      mar_q <= '0;
      mdr_q <= '0;
      err   <= 1'b0;
    end else begin
      err <= err_d;
      if (idle && MARin) mar_q <= BusMuxOut[ADDR_W-1:0];
      if (idle && MDRin) mdr_q <= BusMuxOut;
      else if (state == MEM_RD && mem_ack) mdr_q <= mem_rdata;
    end
  assign mem_req   = in_req;
  assign mem_we    = state == MEM_WR;
  assign busy      = !idle;
  assign done      = state == MEM_FIN;
  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;
endmodule

// File: tb/tb_mdr_mem_interface.sv
// tb_mdr_mem_interface: directed and randomized checks against a RAM-level transaction model
module tb_mdr_mem_interface;
  localparam int TIMEOUT = 16;
  logic clock = 1'b0, clear = 1'b0;
  logic [31:0] BusMuxOut = '0, mem_rdata = '0;
  logic MARin = 1'b0, MDRin = 1'b0, rd_start = 1'b0, wr_start = 1'b0, mem_ack = 1'b0;
  logic mem_req, mem_we, busy, done, err;
  logic [8:0] mem_addr, mar_q;
  logic [31:0] mem_wdata, mdr_q;
  int checks = 0, failures = 0;
  bit [31:0] ram [512];
  logic [8:0] mar_m = '0;
  logic [31:0] mdr_m = '0;

  mdr_mem_interface #(.ADDR_W(9), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .clear(clear), .BusMuxOut(BusMuxOut), .MARin(MARin), .MDRin(MDRin),
    .rd_start(rd_start), .wr_start(wr_start), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mdr_q(mdr_q), .mar_q(mar_q), .busy(busy), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_mar(input logic [31:0] v);
    BusMuxOut = v; MARin = 1'b1;
    step();
    MARin = 1'b0; mar_m = v[8:0];
  endtask

  task automatic load_mdr(input logic [31:0] v);
    BusMuxOut = v; MDRin = 1'b1;
    step();
    MDRin = 1'b0; mdr_m = v;
  endtask

  // One transaction; ack arrives on request cycle delay+1, never if delay >= TIMEOUT
  task automatic run(input string tag, input bit wr, input int delay, input bit poke,
                     input bit co_load, input logic [31:0] co_val);
    int n = 0;
    bit ok = delay < TIMEOUT;
    if (co_load) begin MDRin = 1'b1; BusMuxOut = co_val; mdr_m = co_val; end
    if (wr) wr_start = 1'b1; else rd_start = 1'b1;
    step();
    rd_start = 1'b0; wr_start = 1'b0; MDRin = 1'b0;
    if (co_load) chk({tag, "_coload"}, mdr_q, co_val);
    while (mem_req === 1'b1 && n < 40) begin
      chk({tag, "_we"}, {31'b0, mem_we}, {31'b0, wr});
      chk({tag, "_addr"}, {23'b0, mem_addr}, {23'b0, mar_m});
      if (wr) chk({tag, "_wdata"}, mem_wdata, mdr_m);
      if (poke) begin MDRin = 1'b1; MARin = 1'b1; BusMuxOut = '0; rd_start = 1'b1; end
      if (n == delay) begin mem_ack = 1'b1; mem_rdata = wr ? $urandom : ram[mar_m]; end
      step();
      n++;
      mem_ack = 1'b0; MDRin = 1'b0; MARin = 1'b0; rd_start = 1'b0; mem_rdata = $urandom;
    end
    chk({tag, "_reqcycles"}, n, ok ? delay + 1 : TIMEOUT);
    chk({tag, "_done"}, {31'b0, done}, {31'b0, ok});
    chk({tag, "_err"}, {31'b0, err}, {31'b0, !ok});
    if (ok && wr) ram[mar_m] = mdr_m;
    if (ok && !wr) mdr_m = ram[mar_m];
    chk({tag, "_mdr"}, mdr_q, mdr_m);
    chk({tag, "_mar"}, {23'b0, mar_q}, {23'b0, mar_m});
    chk({tag, "_busy"}, {31'b0, busy}, {31'b0, ok});
    step();
    chk({tag, "_idle"}, {busy, done, err, mem_req}, 4'b0);
  endtask

  initial begin
    step();
    step();
    chk("reset_ctl", {mem_req, mem_we, busy, done, err}, 5'b0);
    chk("reset_mdr", mdr_q, 32'h0);
    chk("reset_mar", {23'b0, mar_q}, 32'h0);
    chk("reset_wdata", mem_wdata, 32'h0);
    chk("reset_addr", {23'b0, mem_addr}, 32'h0);
    clear = 1'b1;
    step();
    load_mar(32'h0000_0123);
    chk("bus_mar", {23'b0, mar_q}, 32'h123);
    load_mdr(32'hDEAD_BEEF);
    chk("bus_mdr", mdr_q, 32'hDEADBEEF);
    ram[9'h010] = 32'hCAFE_0001;
    load_mar(32'h0000_0010);
    run("read", 1'b0, 3, 1'b0, 1'b0, '0);
    chk("read_val", mdr_q, 32'hCAFE0001);
    load_mdr(32'h1234_5678);
    run("write_busy", 1'b1, 2, 1'b1, 1'b0, '0);
    chk("write_keep", mdr_q, 32'h12345678);
    chk("write_ram", ram[9'h010], 32'h12345678);
    run("timeout", 1'b0, 1000, 1'b0, 1'b0, '0);
    chk("timeout_keep", mdr_q, 32'h12345678);
    run("ack_on_timeout", 1'b0, TIMEOUT - 1, 1'b0, 1'b0, '0);
    run("min_latency", 1'b1, 0, 1'b0, 1'b0, '0);
    run("coload_read", 1'b0, 1, 1'b0, 1'b1, 32'h5A5A_A5A5);
    rd_start = 1'b1; wr_start = 1'b1;
    step();
    rd_start = 1'b0; wr_start = 1'b0;
    chk("both_err", {err, done, mem_req, busy}, 4'b1000);
    step();
    chk("both_after", {err, done, mem_req, busy}, 4'b0);
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    step();
    chk("midrst_req", {31'b0, mem_req}, 32'h1);
    clear = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    step();
    clear = 1'b1; mem_ack = 1'b0;
    mar_m = '0; mdr_m = '0;
    chk("midrst_ctl", {mem_req, done, err, busy}, 4'b0);
    chk("midrst_mdr", mdr_q, 32'h0);
    step();
    chk("midrst_after", {mem_req, done, err, busy}, 4'b0);
    for (int i = 0; i < 30; i++) begin
      logic [31:0] a = $urandom_range(0, 31);
      load_mar(a);
      load_mdr($urandom);
      run("rnd_wr", 1'b1, $urandom_range(0, 20), $urandom_range(0, 1) == 1, 1'b0, '0);
      load_mar($urandom_range(0, 31));
      run("rnd_rd", 1'b0, $urandom_range(0, 20), $urandom_range(0, 1) == 1, 1'b0, '0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
